// File: rtl/mem_bus_master.sv
// Single-word bus initiator for memoryInterface: sequences MAR/SRAM/MDR read and write cycles.
// Optional write-verify readback is enabled with `define MEMBUS_WRVERIFY_EN.
module mem_bus_master #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 3,
    parameter int WR_HOLD = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] memAdd,
    output logic              nMemOut,
    output logic              nMemWrite,
    inout  wire  [DATA_W-1:0] memData
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] RD_INIT = 4'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_INIT = 4'(WR_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        TURN
`ifdef MEMBUS_WRVERIFY_EN
        ,
        VERIFY
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_accept;
    logic              w_cnt_zero;

    logic              r_ready;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_memAdd;
    logic              r_nMemOut;
    logic              r_nMemWrite;
    logic              r_drive;
    logic [DATA_W-1:0] r_wdata;

    logic              w_ready_nxt;
    logic              w_done_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [ADDR_W-1:0] w_memAdd_nxt;
    logic              w_nMemOut_nxt;
    logic              w_nMemWrite_nxt;
    logic              w_drive_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;

`ifdef MEMBUS_WRVERIFY_EN
    logic              r_err;
    logic              w_err_nxt;
`endif

    assign w_accept   = (r_state == IDLE) && r_ready && req;
    assign w_cnt_zero = (r_cnt == '0);

    // State register: every registered output is updated here from the output process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_memAdd    <= '0;
            r_nMemOut   <= 1'b1;
            r_nMemWrite <= 1'b1;
            r_drive     <= 1'b0;
            r_wdata     <= '0;
`ifdef MEMBUS_WRVERIFY_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= w_ready_nxt;
            r_done      <= w_done_nxt;
            r_rdata     <= w_rdata_nxt;
            r_memAdd    <= w_memAdd_nxt;
            r_nMemOut   <= w_nMemOut_nxt;
            r_nMemWrite <= w_nMemWrite_nxt;
            r_drive     <= w_drive_nxt;
            r_wdata     <= w_wdata_nxt;
`ifdef MEMBUS_WRVERIFY_EN
            r_err       <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (we) begin
                        w_state_nxt = WRITE;
                        w_cnt_nxt   = WR_INIT;
                    end else begin
                        w_state_nxt = READ;
                        w_cnt_nxt   = RD_INIT;
                    end
                end
            end
            WRITE: begin
                if (w_cnt_zero) begin
`ifdef MEMBUS_WRVERIFY_EN
                    w_state_nxt = VERIFY;
                    w_cnt_nxt   = RD_INIT;
`else
                    w_state_nxt = IDLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            READ: begin
                if (w_cnt_zero) begin
                    w_state_nxt = TURN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
`ifdef MEMBUS_WRVERIFY_EN
            VERIFY: begin
                if (w_cnt_zero) begin
                    w_state_nxt = TURN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
`endif
            TURN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ready lags the IDLE state by one edge and drops on the accepting edge.
    always_comb begin
        w_ready_nxt     = (r_state == IDLE) && !w_accept;
        w_done_nxt      = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_memAdd_nxt    = r_memAdd;
        w_nMemOut_nxt   = r_nMemOut;
        w_nMemWrite_nxt = r_nMemWrite;
        w_drive_nxt     = r_drive;
        w_wdata_nxt     = r_wdata;
`ifdef MEMBUS_WRVERIFY_EN
        w_err_nxt       = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_memAdd_nxt = addr;
                    w_wdata_nxt  = wdata;
                    if (we) begin
                        w_nMemWrite_nxt = 1'b0;
                        w_nMemOut_nxt   = 1'b1;
                        w_drive_nxt     = 1'b1;
                    end else begin
                        w_nMemWrite_nxt = 1'b1;
                        w_nMemOut_nxt   = 1'b0;
                        w_drive_nxt     = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (w_cnt_zero) begin
                    w_nMemWrite_nxt = 1'b1;
                    w_drive_nxt     = 1'b0;
`ifdef MEMBUS_WRVERIFY_EN
                    w_nMemOut_nxt   = 1'b0;
`else
                    w_done_nxt      = 1'b1;
`endif
                end
            end
            READ: begin
                if (w_cnt_zero) begin
                    w_rdata_nxt   = memData;
                    w_done_nxt    = 1'b1;
                    w_nMemOut_nxt = 1'b1;
                end
            end
`ifdef MEMBUS_WRVERIFY_EN
            VERIFY: begin
                if (w_cnt_zero) begin
                    w_rdata_nxt   = memData;
                    w_done_nxt    = 1'b1;
                    w_nMemOut_nxt = 1'b1;
                    w_err_nxt     = r_err | (memData != r_wdata);
                end
            end
`endif
            TURN: begin
                w_nMemOut_nxt   = 1'b1;
                w_nMemWrite_nxt = 1'b1;
                w_drive_nxt     = 1'b0;
            end
            default: begin
                w_nMemOut_nxt   = 1'b1;
                w_nMemWrite_nxt = 1'b1;
                w_drive_nxt     = 1'b0;
            end
        endcase
    end

    assign memData   = r_drive ? r_wdata : 'z;
    assign ready     = r_ready;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign memAdd    = r_memAdd;
    assign nMemOut   = r_nMemOut;
    assign nMemWrite = r_nMemWrite;
`ifdef MEMBUS_WRVERIFY_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a MAR/SRAM/MDR memory model on memData.
module tb_mem_bus_master;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 16;
    localparam int RD_LAT  = 3;
    localparam int WR_HOLD = 3;
`ifdef MEMBUS_WRVERIFY_EN
    localparam int WLAT = WR_HOLD + RD_LAT;
    localparam int WGAP = 2;
`else
    localparam int WLAT = WR_HOLD;
    localparam int WGAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [ADDR_W-1:0] memAdd;
    logic              nMemOut;
    logic              nMemWrite;
    wire  [DATA_W-1:0] memData;

    int total = 0;
    int fails = 0;
    int contention = 0;

    mem_bus_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .WR_HOLD(WR_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .memAdd   (memAdd),
        .nMemOut  (nMemOut),
        .nMemWrite(nMemWrite),
        .memData  (memData)
    );

    always #5 clk = ~clk;

    // Memory model: MAR register, SRAM array with registered output into MDR.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] mar = '0;
    logic [DATA_W-1:0] mdr = '0;
    logic              stuck0 = 1'b0;

    always @(posedge clk) begin
        mar <= memAdd;
        mdr <= mem[mar];
        if (!nMemWrite)
            mem[memAdd] <= stuck0 ? (memData & 16'hFFFE) : memData;
    end

    assign memData = nMemOut ? 16'hzzzz : mdr;

    always @(negedge clk) begin
        if (!rst) begin
            if (!nMemOut && (dut.r_drive || !nMemWrite)) contention++;
            if (!nMemOut && (memData != mdr)) contention++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk("ready_timeout", {31'b0, ready}, 32'd1);
    endtask

    task automatic op(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      output int lat, output int wlow, output logic [DATA_W-1:0] rd);
        wait_ready();
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        req   = 1'b0;
        addr  = 11'h7FF;
        wdata = ~d;
        lat   = 0;
        wlow  = 0;
        rd    = '0;
        @(negedge clk);
        if (!nMemWrite) wlow++;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!nMemWrite) wlow++;
            if (done) begin
                rd = rdata;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int wlow;
        logic [DATA_W-1:0] rd;
        int ops;
        int dones;
        int last_done;
        int saw_done;
        logic prev_we;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_nMemOut", {31'b0, nMemOut}, 32'd1);
        chk("rst_nMemWrite", {31'b0, nMemWrite}, 32'd1);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", {16'b0, rdata}, 32'd0);
        chk("rst_memAdd", {21'b0, memAdd}, 32'd0);
        chk("rst_bus_released", {31'b0, dut.r_drive}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", {31'b0, ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", {31'b0, ready}, 32'd1);

        // Single write then read back
        op(1'b1, 11'h005, 16'hA5A5, lat, wlow, rd);
        chk("wr_latency", lat, WLAT);
        chk("wr_strobe_cycles", wlow, 32'd3);
        chk("wr_err", {31'b0, err}, 32'd0);
        chk("wr_bus_released", {31'b0, dut.r_drive}, 32'd0);
        op(1'b0, 11'h005, 16'h0000, lat, wlow, rd);
        chk("rd_latency", lat, 32'd3);
        chk("rd_no_write_strobe", wlow, 32'd0);
        chk("rd_data", {16'b0, rd}, 32'h0000A5A5);

        // Bulk fill and readback
        for (int i = 0; i < 128; i++) begin
            op(1'b1, 11'(i), 16'(i), lat, wlow, rd);
        end
        for (int i = 0; i < 128; i++) begin
            op(1'b0, 11'(i), 16'h0000, lat, wlow, rd);
            chk("bulk_rd_data", {16'b0, rd}, i);
            chk("bulk_rd_latency", lat, 32'd3);
        end
        chk("bulk_contention", contention, 32'd0);
`ifndef MEMBUS_WRVERIFY_EN
        chk("err_tied_low", {31'b0, err}, 32'd0);
`endif

        // req held high with alternating we
        wait_ready();
        req       = 1'b1;
        we        = 1'b1;
        addr      = 11'h010;
        wdata     = 16'h1234;
        ops       = 0;
        dones     = 0;
        last_done = 0;
        prev_we   = 1'b1;
        for (int c = 0; c < 80 && ops < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (done) begin
                last_done = c;
                dones++;
                if (!prev_we) chk("alt_rd_data", {16'b0, rdata}, 32'h00001234);
            end
            if (ready) begin
                if (ops > 0) begin
                    chk("alt_ready_gap", c - last_done, prev_we ? WGAP : 2);
                    chk("alt_one_done", dones, 32'd1);
                end
                prev_we = we;
                ops++;
                dones = 0;
                @(posedge clk);
                #1;
                we = ~we;
            end
        end
        req = 1'b0;
        chk("alt_op_count", ops, 32'd6);
        repeat (10) @(negedge clk);

        // Reset during the second cycle of a read
        wait_ready();
        req  = 1'b1;
        we   = 1'b0;
        addr = 11'h020;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'b0, ready}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_nMemOut", {31'b0, nMemOut}, 32'd1);
        chk("mid_rst_nMemWrite", {31'b0, nMemWrite}, 32'd1);
        chk("mid_rst_memAdd", {21'b0, memAdd}, 32'd0);
        chk("mid_rst_rdata", {16'b0, rdata}, 32'd0);
        chk("mid_rst_bus_released", {31'b0, dut.r_drive}, 32'd0);
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("mid_rst_no_done", saw_done, 32'd0);
        op(1'b0, 11'h020, 16'h0000, lat, wlow, rd);
        chk("post_rst_rd_latency", lat, 32'd3);
        chk("post_rst_rd_data", {16'b0, rd}, 32'h00000020);

`ifdef MEMBUS_WRVERIFY_EN
        // Write-verify with SRAM bit 0 stuck at 0
        stuck0 = 1'b1;
        op(1'b1, 11'h030, 16'h0001, lat, wlow, rd);
        chk("vfy_latency", lat, 32'd6);
        chk("vfy_rdata", {16'b0, rd}, 32'h00000000);
        chk("vfy_err_set", {31'b0, err}, 32'd1);
        stuck0 = 1'b0;
        op(1'b1, 11'h031, 16'h0002, lat, wlow, rd);
        chk("vfy_good_rdata", {16'b0, rd}, 32'h00000002);
        chk("vfy_err_sticky", {31'b0, err}, 32'd1);
        op(1'b1, 11'h032, 16'h0004, lat, wlow, rd);
        chk("vfy_err_sticky2", {31'b0, err}, 32'd1);
`endif

        chk("final_contention", contention, 32'd0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
